// File: rtl/axis_to_vector.sv
// AXI-Stream to parallel vector: assembles N = VEC_BYTES/AXIS_BYTES beats into one
// vector, publishes it only on a well-formed frame, and flags short/long frames.

module axis_to_vector_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         sresetn,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_nxt
);
  // q_nxt lets the top publish a frame on the same edge its last beat lands
  assign q_nxt = we ? d : q;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module axis_to_vector #(
  parameter int VEC_BYTES  = 2,
  parameter int AXIS_BYTES = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    sresetn,
  input  logic [AXIS_BYTES*8-1:0] axis_tdata,
  input  logic [AXIS_BYTES-1:0]   axis_tkeep,
  input  logic                    axis_tlast,
  input  logic                    axis_tvalid,
  output logic                    axis_tready,
  output logic [VEC_BYTES*8-1:0]  vec,
  output logic                    vec_valid,
  output logic                    frame_err
);
  localparam int N  = VEC_BYTES / AXIS_BYTES;
  localparam int SW = AXIS_BYTES * 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CTR_INIT = (MSB_FIRST != 0) ? CW'(N-1) : '0;
  localparam logic [CW-1:0] CTR_LAST = (MSB_FIRST != 0) ? '0 : CW'(N-1);

  generate
    if ((VEC_BYTES % AXIS_BYTES) != 0 || N < 1) begin : g_bad_params
      $error("axis_to_vector: VEC_BYTES must be a nonzero multiple of AXIS_BYTES");
    end
  endgenerate

  typedef enum logic {ASSEMBLE, DISCARD} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       ctr, ctr_nxt;
  logic                accept, at_last, wr_en, done, err;
  logic [N-1:0][SW-1:0] asm_q, asm_nxt;
  logic                unused_keep;

  // tkeep is defined as all-ones by the source; it carries no information here
  assign unused_keep = ^axis_tkeep;

  assign accept  = axis_tvalid & axis_tready;
  assign at_last = (ctr == CTR_LAST);

  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    wr_en     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    if (accept) begin
      case (state)
        ASSEMBLE: begin
          wr_en = 1'b1;
          if (axis_tlast) begin
            ctr_nxt = CTR_INIT;
            if (at_last) done = 1'b1;
            else         err  = 1'b1;
          end else if (at_last) begin
            ctr_nxt   = CTR_INIT;
            err       = 1'b1;
            state_nxt = DISCARD;
          end else begin
            ctr_nxt = (MSB_FIRST != 0) ? ctr - CW'(1) : ctr + CW'(1);
          end
        end
        DISCARD: begin
          // stay silent until the oversized frame finally ends
          if (axis_tlast) begin
            state_nxt = ASSEMBLE;
            ctr_nxt   = CTR_INIT;
          end
        end
        default: state_nxt = ASSEMBLE;
      endcase
    end
  end

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_slot
      axis_to_vector_slot #(.W(SW)) u_slot (
        .clk     (clk),
        .sresetn (sresetn),
        .we      (wr_en && (ctr == CW'(i))),
        .d       (axis_tdata),
        .q       (asm_q[i]),
        .q_nxt   (asm_nxt[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state       <= ASSEMBLE;
      ctr         <= CTR_INIT;
      axis_tready <= 1'b0;
      vec         <= '0;
      vec_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ctr         <= ctr_nxt;
      axis_tready <= 1'b1;
      vec_valid   <= done;
      frame_err   <= err;
      if (done) vec <= asm_nxt;
    end
  end
endmodule

// File: tb/tb_axis_to_vector.sv
// Directed table-driven bench: three instances (4x1 LSB-first, 4x1 MSB-first, 2x2).
module tb_axis_to_vector;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic [15:0] td  [3];
  logic        tl  [3];
  logic        tv  [3];

  logic        rdy_a, rdy_b, rdy_c;
  logic [31:0] vec_a, vec_b;
  logic [15:0] vec_c;
  logic        vv_a, vv_b, vv_c, er_a, er_b, er_c;

  axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(0)) u_a (
    .clk(clk), .sresetn(rst[0]), .axis_tdata(td[0][7:0]), .axis_tkeep(1'b1),
    .axis_tlast(tl[0]), .axis_tvalid(tv[0]), .axis_tready(rdy_a),
    .vec(vec_a), .vec_valid(vv_a), .frame_err(er_a));

  axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1)) u_b (
    .clk(clk), .sresetn(rst[1]), .axis_tdata(td[1][7:0]), .axis_tkeep(1'b1),
    .axis_tlast(tl[1]), .axis_tvalid(tv[1]), .axis_tready(rdy_b),
    .vec(vec_b), .vec_valid(vv_b), .frame_err(er_b));

  axis_to_vector #(.VEC_BYTES(2), .AXIS_BYTES(2), .MSB_FIRST(0)) u_c (
    .clk(clk), .sresetn(rst[2]), .axis_tdata(td[2]), .axis_tkeep(2'b11),
    .axis_tlast(tl[2]), .axis_tvalid(tv[2]), .axis_tready(rdy_c),
    .vec(vec_c), .vec_valid(vv_c), .frame_err(er_c));

  typedef struct {
    int          dut;
    logic [15:0] d;
    logic        l;
    logic        v;
    logic [31:0] ev;
    logic        evv;
    logic        eerr;
  } row_t;

  row_t tbl[$];
  int   applied = 0;
  int   errs    = 0;

  function automatic void add(int dut, logic [15:0] d, logic l, logic v,
                              logic [31:0] ev, logic evv, logic eerr);
    row_t r;
    r.dut = dut; r.d = d; r.l = l; r.v = v; r.ev = ev; r.evv = evv; r.eerr = eerr;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input row_t r, input string tag);
    logic [31:0] av;
    logic        avv, aer;
    @(negedge clk);
    for (int k = 0; k < 3; k++) tv[k] = 1'b0;
    td[r.dut] = r.d;
    tl[r.dut] = r.l;
    tv[r.dut] = r.v;
    @(posedge clk);
    #1;
    case (r.dut)
      0:       begin av = vec_a;          avv = vv_a; aer = er_a; end
      1:       begin av = vec_b;          avv = vv_b; aer = er_b; end
      default: begin av = {16'h0, vec_c}; avv = vv_c; aer = er_c; end
    endcase
    chk({tag, " vec"}, av, r.ev);
    chk({tag, " vec_valid"}, {31'd0, avv}, {31'd0, r.evv});
    chk({tag, " frame_err"}, {31'd0, aer}, {31'd0, r.eerr});
  endtask

  initial begin
    row_t r;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; td[k] = '0; tl[k] = 1'b0; tv[k] = 1'b0;
    end

    // DUT A, LSB-first 4x1: good frame, invalid-cycle noise, short, good, long, good
    add(0, 16'h11, 0, 1, 32'h0, 0, 0);
    add(0, 16'h22, 0, 1, 32'h0, 0, 0);
    add(0, 16'h33, 0, 1, 32'h0, 0, 0);
    add(0, 16'h44, 1, 1, 32'h44332211, 1, 0);
    add(0, 16'hFF, 1, 0, 32'h44332211, 0, 0);
    add(0, 16'hAA, 0, 1, 32'h44332211, 0, 0);
    add(0, 16'hBB, 1, 1, 32'h44332211, 0, 1);
    add(0, 16'h00, 0, 0, 32'h44332211, 0, 0);
    add(0, 16'h01, 0, 1, 32'h44332211, 0, 0);
    add(0, 16'h02, 0, 1, 32'h44332211, 0, 0);
    add(0, 16'h03, 0, 1, 32'h44332211, 0, 0);
    add(0, 16'h04, 1, 1, 32'h04030201, 1, 0);
    add(0, 16'h01, 0, 1, 32'h04030201, 0, 0);
    add(0, 16'h02, 0, 1, 32'h04030201, 0, 0);
    add(0, 16'h03, 0, 1, 32'h04030201, 0, 0);
    add(0, 16'h04, 0, 1, 32'h04030201, 0, 1);
    add(0, 16'h55, 0, 1, 32'h04030201, 0, 0);
    add(0, 16'h66, 1, 1, 32'h04030201, 0, 0);
    add(0, 16'hA1, 0, 1, 32'h04030201, 0, 0);
    add(0, 16'hB2, 0, 1, 32'h04030201, 0, 0);
    add(0, 16'hC3, 0, 1, 32'h04030201, 0, 0);
    add(0, 16'hD4, 1, 1, 32'hD4C3B2A1, 1, 0);
    add(0, 16'h00, 0, 0, 32'hD4C3B2A1, 0, 0);
    // DUT B, MSB-first: back-to-back, then the same shape with gaps
    add(1, 16'h11, 0, 1, 32'h0, 0, 0);
    add(1, 16'h22, 0, 1, 32'h0, 0, 0);
    add(1, 16'h33, 0, 1, 32'h0, 0, 0);
    add(1, 16'h44, 1, 1, 32'h11223344, 1, 0);
    add(1, 16'h55, 0, 1, 32'h11223344, 0, 0);
    add(1, 16'h00, 0, 0, 32'h11223344, 0, 0);
    add(1, 16'h66, 0, 1, 32'h11223344, 0, 0);
    add(1, 16'h00, 1, 0, 32'h11223344, 0, 0);
    add(1, 16'h00, 0, 0, 32'h11223344, 0, 0);
    add(1, 16'h77, 0, 1, 32'h11223344, 0, 0);
    add(1, 16'h88, 1, 1, 32'h55667788, 1, 0);
    add(1, 16'h00, 0, 0, 32'h55667788, 0, 0);
    // DUT C, single-beat frames: good, long (discard), good
    add(2, 16'hBEEF, 1, 1, 32'hBEEF, 1, 0);
    add(2, 16'h1234, 0, 1, 32'hBEEF, 0, 1);
    add(2, 16'h1111, 0, 1, 32'hBEEF, 0, 0);
    add(2, 16'h5678, 1, 1, 32'hBEEF, 0, 0);
    add(2, 16'h9ABC, 1, 1, 32'h9ABC, 1, 0);
    add(2, 16'h0000, 0, 0, 32'h9ABC, 0, 0);

    // reset state, checked asynchronously before any clock edge
    #2;
    chk("rst tready", {29'd0, rdy_a, rdy_b, rdy_c}, 32'd0);
    chk("rst vec_a", vec_a, 32'd0);
    chk("rst vec_b", vec_b, 32'd0);
    chk("rst vec_c", {16'd0, vec_c}, 32'd0);
    chk("rst pulses", {26'd0, vv_a, vv_b, vv_c, er_a, er_b, er_c}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    #1 chk("tready first cycle", {29'd0, rdy_a, rdy_b, rdy_c}, 32'd0);
    @(posedge clk);
    #1 chk("tready after release", {29'd0, rdy_a, rdy_b, rdy_c}, 32'd7);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // reset in the middle of a frame on DUT A
    r = '{dut: 0, d: 16'hDE, l: 0, v: 1, ev: 32'hD4C3B2A1, evv: 0, eerr: 0};
    apply(r, "pre-rst DE");
    r.d = 16'hAD;
    apply(r, "pre-rst AD");
    @(negedge clk);
    tv[0] = 1'b0;
    rst[0] = 1'b0;
    #1;
    chk("mid-rst vec", vec_a, 32'd0);
    chk("mid-rst tready", {31'd0, rdy_a}, 32'd0);
    @(posedge clk);
    #1 chk("mid-rst tready held", {31'd0, rdy_a}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b1;
    td[0] = 16'h99; tl[0] = 1'b1; tv[0] = 1'b1;
    #1 chk("post-rst tready low", {31'd0, rdy_a}, 32'd0);
    @(posedge clk);
    #1;
    chk("post-rst tready high", {31'd0, rdy_a}, 32'd1);
    chk("post-rst ignored beat", {vec_a[29:0], vv_a, er_a}, 32'd0);
    r = '{dut: 0, d: 16'hDE, l: 0, v: 1, ev: 32'h0, evv: 0, eerr: 0};
    apply(r, "post-rst DE");
    r.d = 16'hAD; apply(r, "post-rst AD");
    r.d = 16'hBE; apply(r, "post-rst BE");
    r.d = 16'hEF; r.l = 1; r.ev = 32'hEFBEADDE; r.evv = 1;
    apply(r, "post-rst EF");
    r.v = 0; r.l = 0; r.evv = 0;
    apply(r, "post-rst idle");

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end
endmodule
